rcv_field_shifter: RTL and testbench
====================================

RCV_FIELD_SHIFTER -- requirements
Module: rcv_field_shifter

Interface
REQ-001 SHALL have parameter SYNC_W, default 8, sync field width in bits.
REQ-002 SHALL have parameters PID_W=8, CRC5_W=5, CRC16_W=16 and DATA_W=64, each the width of that field in bits.
REQ-003 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-004 SHALL have port n_rst, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port shift_strobe, input, 1, one-cycle pulse, one decoded bit valid.
REQ-006 SHALL have port d_orig, input, 1, NRZI-decoded bit, sampled when shift_strobe=1.
REQ-007 SHALL have port eop, input, 1, end-of-packet detected.
REQ-008 SHALL have ports sync_rcving, pid_rcving, crc5_rcving, crc16_rcving, data_rcving, input, 1 each, field-select levels from the receiver control unit.
REQ-009 SHALL have ports rcv_sync[7:0], rcv_pid[7:0], rcv_crc5[4:0], rcv_crc16[15:0], rcv_data[63:0], output, field contents.
REQ-010 SHALL have ports sync/pid/crc5/crc16/data_bits_received, output, 1 each, field-complete pulses.
REQ-011 SHALL have port stuff_error, output, 1, one-cycle pulse on a bit-stuff violation.

Function
REQ-012 SHALL resolve the active field by priority sync > pid > crc5 > crc16 > data; none asserted = IDLE.
REQ-013 SHALL, on the first cycle a field becomes active (active field differs from last cycle's registered value), clear that field's register and bit counter to 0, even if shift_strobe is also high that cycle.
REQ-014 SHALL, on shift_strobe with an accepted bit, shift LSB-first: field <= {d_orig, field[W-1:1]}, and increment the bit counter.
REQ-015 SHALL assert <field>_bits_received for exactly one cycle, registered, in the cycle after the strobe carrying bit W of that field.
REQ-016 SHALL ignore strobes once the bit counter equals W (no shift, no further pulse) until the field is re-entered.
REQ-017 SHALL hold each field register unchanged while its field is inactive.
REQ-018 SHALL count consecutive accepted 1 bits (0..6) across field boundaries within a packet.
REQ-019 SHALL treat the strobed bit after six consecutive 1s as a stuff bit: not shifted, not counted; ones counter cleared.
REQ-020 SHALL pulse stuff_error one cycle after a stuff bit that equals 1.
REQ-021 SHALL clear the ones counter on eop=1 or when IDLE.
REQ-022 SHALL ignore shift_strobe in IDLE (no register changes).
REQ-023 SHALL make outputs direct register outputs, with no combinational path from inputs.

Reset
REQ-024 SHALL asynchronously clear all field registers, bit counters, the ones counter, the previous-field register and all pulse outputs to 0 when n_rst=0, including mid-field.
REQ-025 SHALL resume in IDLE after reset release; a field already active at release counts as newly entered.

Structure
REQ-026 SHALL take field widths and the field enum (IDLE, SYNC, PID, CRC5, CRC16, DATA) from shared package usb_rcv_pkg.
REQ-027 SHALL implement the bit counter as one instance of sub-module flex_counter (parameterised width, clear, count_enable, rollover_val).

Verification
REQ-028 SHALL test sync: sync_rcving=1, strobe bits 0,0,0,0,0,0,0,1 -> rcv_sync=8'h80, sync_bits_received pulses once, one cycle after the 8th strobe.
REQ-029 SHALL test PID then CRC5: pid_rcving with LSB-first bits of 8'h96, then crc5_rcving with 5 bits of 5'h1B -> rcv_pid=8'h96, rcv_crc5=5'h1B, one pulse each.
REQ-030 SHALL test stuffing: data_rcving, bits 1,1,1,1,1,1,0(stuff),1 -> 7 bits counted, 0 not shifted, no stuff_error; repeat with stuff bit 1 -> stuff_error pulse, bit dropped.
REQ-031 SHALL test overrun: 10 strobes during crc5_rcving -> only first 5 bits captured, single crc5_bits_received.
REQ-032 SHALL test reset mid-field: n_rst low after 30 data bits -> all outputs 0 immediately; re-entry of data_rcving needs a full 64 bits for data_bits_received.
REQ-033 SHALL test priority: sync_rcving and data_rcving both high with 8 strobes -> only rcv_sync changes, rcv_data unchanged.

Source files
------------

// File: rtl/usb_rcv_pkg.sv
`default_nettype none
// ============================================================================
// Package   : usb_rcv_pkg
// Purpose   : Shared field widths, field enumeration and field-priority helper
//             for the USB receive datapath.
// Revision  : 1.0 - initial release
// ============================================================================
package usb_rcv_pkg;

   localparam int SYNC_WIDTH  = 8;
   localparam int PID_WIDTH   = 8;
   localparam int CRC5_WIDTH  = 5;
   localparam int CRC16_WIDTH = 16;
   localparam int DATA_WIDTH  = 64;

   // Number of consecutive 1s after which the next bit is a stuff bit
   localparam logic [2:0] STUFF_RUN = 3'd6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      PID   = 3'd2,
      CRC5  = 3'd3,
      CRC16 = 3'd4,
      DATA  = 3'd5
   } field_e;

   // Highest-priority asserted field select wins; nothing asserted is IDLE
   function automatic field_e resolve_field(input logic s, input logic p,
                                            input logic c5, input logic c16,
                                            input logic d);
      field_e f;
      if (s)        f = SYNC;
      else if (p)   f = PID;
      else if (c5)  f = CRC5;
      else if (c16) f = CRC16;
      else if (d)   f = DATA;
      else          f = IDLE;
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rcv_field_shifter_flex_counter.sv
`default_nettype none
// ============================================================================
// Module    : flex_counter
// Purpose   : Width-parameterised up-counter with synchronous clear, count
//             enable, and a flag raised while the count equals rollover_val.
// Revision  : 1.0 - initial release
// ============================================================================
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   // Count register: clear has priority, wraps to 1 after reaching rollover_val
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_out <= '0;
      end else if (clear) begin
         count_out <= '0;
      end else if (count_enable) begin
         if (count_out == rollover_val)
            count_out <= NUM_CNT_BITS'(1);
         else
            count_out <= count_out + NUM_CNT_BITS'(1);
      end
   end

   // Flag derived purely from the count register
   always_comb begin
      rollover_flag = (count_out == rollover_val);
   end

endmodule
`default_nettype wire

// File: rtl/rcv_field_shifter.sv
`default_nettype none
// ============================================================================
// Module    : rcv_field_shifter
// Purpose   : Deserialises NRZI-decoded USB bits LSB-first into the packet
//             field selected by the receiver control unit, strips stuff bits
//             and flags stuffing violations.
// Revision  : 1.0 - initial release
// ============================================================================
module rcv_field_shifter
   import usb_rcv_pkg::*;
#(
   parameter int SYNC_W  = SYNC_WIDTH,
   parameter int PID_W   = PID_WIDTH,
   parameter int CRC5_W  = CRC5_WIDTH,
   parameter int CRC16_W = CRC16_WIDTH,
   parameter int DATA_W  = DATA_WIDTH
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               shift_strobe,
   input  logic               d_orig,
   input  logic               eop,
   input  logic               sync_rcving,
   input  logic               pid_rcving,
   input  logic               crc5_rcving,
   input  logic               crc16_rcving,
   input  logic               data_rcving,
   output logic [SYNC_W-1:0]  rcv_sync,
   output logic [PID_W-1:0]   rcv_pid,
   output logic [CRC5_W-1:0]  rcv_crc5,
   output logic [CRC16_W-1:0] rcv_crc16,
   output logic [DATA_W-1:0]  rcv_data,
   output logic               sync_bits_received,
   output logic               pid_bits_received,
   output logic               crc5_bits_received,
   output logic               crc16_bits_received,
   output logic               data_bits_received,
   output logic               stuff_error
);

   localparam int MAX_A = (SYNC_W > PID_W)   ? SYNC_W : PID_W;
   localparam int MAX_B = (CRC5_W > CRC16_W) ? CRC5_W : CRC16_W;
   localparam int MAX_C = (MAX_A > MAX_B)    ? MAX_A  : MAX_B;
   localparam int MAX_W = (MAX_C > DATA_W)   ? MAX_C  : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);

   field_e             cur_field;
   field_e             prev_field;
   logic               new_entry;
   logic [CNT_W-1:0]   field_w;
   logic [CNT_W-1:0]   bit_count;
   logic               field_full;
   logic               strobe_live;
   logic               stuff_bit;
   logic               shift_bit;
   logic               last_bit;
   logic [2:0]         ones_count;

   // Field resolution, width lookup and per-strobe qualification
   always_comb begin
      cur_field   = resolve_field(sync_rcving, pid_rcving, crc5_rcving,
                                  crc16_rcving, data_rcving);
      new_entry   = (cur_field != prev_field);
      field_w     = '0;
      case (cur_field)
         SYNC:    field_w = CNT_W'(SYNC_W);
         PID:     field_w = CNT_W'(PID_W);
         CRC5:    field_w = CNT_W'(CRC5_W);
         CRC16:   field_w = CNT_W'(CRC16_W);
         DATA:    field_w = CNT_W'(DATA_W);
         default: field_w = '0;
      endcase
      // The entry cycle only clears; a strobe arriving then is dropped
      strobe_live = shift_strobe && (cur_field != IDLE) && !new_entry && !field_full;
      stuff_bit   = strobe_live && (ones_count == STUFF_RUN);
      shift_bit   = strobe_live && (ones_count != STUFF_RUN);
      last_bit    = (bit_count == (field_w - CNT_W'(1)));
   end

   // Shared bit counter: restarted on every field entry, stops at field width
   flex_counter #(
      .NUM_CNT_BITS (CNT_W)
   ) u_bit_counter (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (new_entry),
      .count_enable  (shift_bit),
      .rollover_val  (field_w),
      .count_out     (bit_count),
      .rollover_flag (field_full)
   );

   // Field registers: cleared on entry, LSB-first shift on accepted bits
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_field <= IDLE;
         rcv_sync   <= '0;
         rcv_pid    <= '0;
         rcv_crc5   <= '0;
         rcv_crc16  <= '0;
         rcv_data   <= '0;
      end else begin
         prev_field <= cur_field;
         if (new_entry) begin
            case (cur_field)
               SYNC:    rcv_sync  <= '0;
               PID:     rcv_pid   <= '0;
               CRC5:    rcv_crc5  <= '0;
               CRC16:   rcv_crc16 <= '0;
               DATA:    rcv_data  <= '0;
               default: ;
            endcase
         end else if (shift_bit) begin
            case (cur_field)
               SYNC:    rcv_sync  <= {d_orig, rcv_sync[SYNC_W-1:1]};
               PID:     rcv_pid   <= {d_orig, rcv_pid[PID_W-1:1]};
               CRC5:    rcv_crc5  <= {d_orig, rcv_crc5[CRC5_W-1:1]};
               CRC16:   rcv_crc16 <= {d_orig, rcv_crc16[CRC16_W-1:1]};
               DATA:    rcv_data  <= {d_orig, rcv_data[DATA_W-1:1]};
               default: ;
            endcase
         end
      end
   end

   // Run length of accepted 1s; survives field changes but not EOP or IDLE
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ones_count <= '0;
      end else if (eop || (cur_field == IDLE)) begin
         ones_count <= '0;
      end else if (stuff_bit) begin
         ones_count <= '0;
      end else if (shift_bit) begin
         ones_count <= d_orig ? (ones_count + 3'd1) : 3'd0;
      end
   end

   // Registered one-cycle completion and stuffing-violation pulses
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_bits_received  <= 1'b0;
         pid_bits_received   <= 1'b0;
         crc5_bits_received  <= 1'b0;
         crc16_bits_received <= 1'b0;
         data_bits_received  <= 1'b0;
         stuff_error         <= 1'b0;
      end else begin
         sync_bits_received  <= shift_bit && last_bit && (cur_field == SYNC);
         pid_bits_received   <= shift_bit && last_bit && (cur_field == PID);
         crc5_bits_received  <= shift_bit && last_bit && (cur_field == CRC5);
         crc16_bits_received <= shift_bit && last_bit && (cur_field == CRC16);
         data_bits_received  <= shift_bit && last_bit && (cur_field == DATA);
         stuff_error         <= stuff_bit && d_orig;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rcv_field_shifter.sv
`default_nettype none
// ============================================================================
// Module    : tb_rcv_field_shifter
// Purpose   : Self-checking bench for rcv_field_shifter: table of whole-field
//             transfers, hand-written corner sequences and random traffic,
//             all compared every cycle against a bit-list reference model.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_rcv_field_shifter;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        shift_strobe = 1'b0, d_orig = 1'b0, eop = 1'b0;
   logic        sync_rcving = 1'b0, pid_rcving = 1'b0, crc5_rcving = 1'b0;
   logic        crc16_rcving = 1'b0, data_rcving = 1'b0;
   logic [7:0]  rcv_sync, rcv_pid;
   logic [4:0]  rcv_crc5;
   logic [15:0] rcv_crc16;
   logic [63:0] rcv_data;
   logic        sync_bits_received, pid_bits_received, crc5_bits_received;
   logic        crc16_bits_received, data_bits_received, stuff_error;

   rcv_field_shifter dut (
      .clk (clk), .n_rst (n_rst), .shift_strobe (shift_strobe), .d_orig (d_orig),
      .eop (eop), .sync_rcving (sync_rcving), .pid_rcving (pid_rcving),
      .crc5_rcving (crc5_rcving), .crc16_rcving (crc16_rcving),
      .data_rcving (data_rcving), .rcv_sync (rcv_sync), .rcv_pid (rcv_pid),
      .rcv_crc5 (rcv_crc5), .rcv_crc16 (rcv_crc16), .rcv_data (rcv_data),
      .sync_bits_received (sync_bits_received), .pid_bits_received (pid_bits_received),
      .crc5_bits_received (crc5_bits_received), .crc16_bits_received (crc16_bits_received),
      .data_bits_received (data_bits_received), .stuff_error (stuff_error)
   );

   always #5 clk = ~clk;

   // Field index: 0 idle, 1 sync, 2 pid, 3 crc5, 4 crc16, 5 data
   int          WID [6] = '{0, 8, 8, 5, 16, 64};
   string       FNAME [6] = '{"idle", "sync", "pid", "crc5", "crc16", "data"};

   // Reference model: arrival-ordered bits per field plus a ones run length
   logic [63:0] m_acc [6];
   int          m_cnt [6];
   int          m_ones;
   int          m_prev;

   int          n_vec = 0;
   int          n_miss = 0;
   int          obs_pulses;
   int          obs_serr;

   typedef struct {
      logic [4:0]  sel;
      logic [63:0] bits;
      int          n;
      logic [63:0] exp_val;
      int          exp_pulses;
   } vec_t;

   function automatic int prio(input logic [4:0] sel);
      if (sel[4]) return 1;
      if (sel[3]) return 2;
      if (sel[2]) return 3;
      if (sel[1]) return 4;
      if (sel[0]) return 5;
      return 0;
   endfunction

   // Register value: the received bits sit at the top, first bit lowest
   function automatic logic [63:0] exp_val(input int f);
      logic [63:0] mask;
      mask = (WID[f] == 64) ? {64{1'b1}} : ((64'd1 << WID[f]) - 64'd1);
      return (m_acc[f] << (WID[f] - m_cnt[f])) & mask;
   endfunction

   function automatic logic [63:0] get_reg(input int f);
      case (f)
         1:       return {56'd0, rcv_sync};
         2:       return {56'd0, rcv_pid};
         3:       return {59'd0, rcv_crc5};
         4:       return {48'd0, rcv_crc16};
         default: return rcv_data;
      endcase
   endfunction

   function automatic logic get_pulse(input int f);
      case (f)
         1:       return sync_bits_received;
         2:       return pid_bits_received;
         3:       return crc5_bits_received;
         4:       return crc16_bits_received;
         default: return data_bits_received;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 6; k++) begin
         m_acc[k] = '0;
         m_cnt[k] = 0;
      end
      m_ones = 0;
      m_prev = 0;
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge
   task automatic step(input logic stb, input logic d, input logic e, input logic [4:0] sel);
      int         f;
      logic [5:0] ep;
      logic       es;
      shift_strobe = stb;
      d_orig       = d;
      eop          = e;
      {sync_rcving, pid_rcving, crc5_rcving, crc16_rcving, data_rcving} = sel;
      f  = prio(sel);
      ep = '0;
      es = 1'b0;
      if (f != m_prev) begin
         if (f != 0) begin
            m_acc[f] = '0;
            m_cnt[f] = 0;
         end
      end else if (stb && f != 0 && m_cnt[f] < WID[f]) begin
         if (m_ones == 6) begin
            m_ones = 0;
            es     = d;
         end else begin
            m_acc[f][m_cnt[f]] = d;
            m_cnt[f]++;
            m_ones = d ? m_ones + 1 : 0;
            ep[f]  = (m_cnt[f] == WID[f]);
         end
      end
      if (e || f == 0) m_ones = 0;
      m_prev = f;
      @(posedge clk);
      #1;
      for (int k = 1; k <= 5; k++) begin
         chk({"rcv_", FNAME[k]}, get_reg(k), exp_val(k));
         chk({FNAME[k], "_bits_received"}, 64'(get_pulse(k)), 64'(ep[k]));
         if (get_pulse(k)) obs_pulses++;
      end
      chk("stuff_error", 64'(stuff_error), 64'(es));
      if (stuff_error) obs_serr++;
   endtask

   task automatic chk_all_zero(input string tag);
      for (int k = 1; k <= 5; k++) begin
         chk({tag, "_rcv_", FNAME[k]}, get_reg(k), 64'd0);
         chk({tag, "_", FNAME[k], "_pulse"}, 64'(get_pulse(k)), 64'd0);
      end
      chk({tag, "_stuff_error"}, 64'(stuff_error), 64'd0);
   endtask

   vec_t tbl [7];

   initial begin
      logic [4:0] rsel;
      int         seg;

      tbl[0] = '{5'b10000, 64'h80,                  8,  64'h80,                  1};
      tbl[1] = '{5'b01000, 64'h96,                  8,  64'h96,                  1};
      tbl[2] = '{5'b00100, 64'h1B,                  5,  64'h1B,                  1};
      tbl[3] = '{5'b00100, 64'h3EA,                 10, 64'h0A,                  1};
      tbl[4] = '{5'b00010, 64'hBEEF,                16, 64'hBEEF,                1};
      tbl[5] = '{5'b00001, 64'h0123_4567_89AB_CDEF, 64, 64'h0123_4567_89AB_CDEF, 1};
      tbl[6] = '{5'b00001, 64'hA5,                  8,  64'hA500_0000_0000_0000, 0};

      model_reset();
      n_rst = 1'b0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      n_rst = 1'b1;

      // Whole-field transfers; PID is followed directly by CRC5 (table order)
      foreach (tbl[i]) begin
         int f;
         f = prio(tbl[i].sel);
         obs_pulses = 0;
         if (i != 2) step(1'b0, 1'b0, 1'b0, 5'b00000);
         step(1'b0, 1'b0, 1'b0, tbl[i].sel);
         for (int b = 0; b < tbl[i].n; b++) step(1'b1, tbl[i].bits[b], 1'b0, tbl[i].sel);
         step(1'b0, 1'b0, 1'b0, tbl[i].sel);
         chk({"tbl_val_", FNAME[f]}, get_reg(f), tbl[i].exp_val);
         chk({"tbl_pulses_", FNAME[f]}, 64'(obs_pulses), 64'(tbl[i].exp_pulses));
      end

      // Stuffing: six 1s, stuff bit, one more 1; stuff bit 0 then stuff bit 1
      for (int rep = 0; rep < 2; rep++) begin
         obs_serr = 0;
         step(1'b0, 1'b0, 1'b0, 5'b00000);
         step(1'b0, 1'b0, 1'b0, 5'b00001);
         for (int b = 0; b < 6; b++) step(1'b1, 1'b1, 1'b0, 5'b00001);
         step(1'b1, (rep == 1), 1'b0, 5'b00001);
         step(1'b1, 1'b1, 1'b0, 5'b00001);
         step(1'b0, 1'b0, 1'b0, 5'b00001);
         chk("stuff_data_val", rcv_data, 64'hFE00_0000_0000_0000);
         chk("stuff_err_count", 64'(obs_serr), 64'(rep));
      end

      // Asynchronous reset in the middle of a data field
      step(1'b0, 1'b0, 1'b0, 5'b00000);
      step(1'b0, 1'b0, 1'b0, 5'b00001);
      for (int b = 0; b < 30; b++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 5'b00001);
      #2;
      n_rst = 1'b0;
      #1;
      chk_all_zero("midreset");
      model_reset();
      @(negedge clk);
      n_rst = 1'b1;
      obs_pulses = 0;
      step(1'b0, 1'b0, 1'b0, 5'b00001);
      for (int b = 0; b < 63; b++) step(1'b1, 1'b0, 1'b0, 5'b00001);
      chk("reentry_63_pulses", 64'(obs_pulses), 64'd0);
      step(1'b1, 1'b1, 1'b0, 5'b00001);
      chk("reentry_64_pulses", 64'(obs_pulses), 64'd1);
      chk("reentry_data_val", rcv_data, 64'h8000_0000_0000_0000);

      // Priority: sync and data both selected, only sync captures
      step(1'b0, 1'b0, 1'b0, 5'b00000);
      step(1'b0, 1'b0, 1'b0, 5'b10001);
      for (int b = 0; b < 8; b++) step(1'b1, ((8'h3C >> b) & 8'h1) != 0, 1'b0, 5'b10001);
      step(1'b0, 1'b0, 1'b0, 5'b10001);
      chk("prio_sync_val", {56'd0, rcv_sync}, 64'h3C);
      chk("prio_data_held", rcv_data, 64'h8000_0000_0000_0000);

      // Random traffic: held field selects, 1-biased bits, occasional EOP
      for (int s = 0; s < 60; s++) begin
         case ($urandom_range(0, 3))
            0:       rsel = 5'b00000;
            1:       rsel = 5'($urandom_range(0, 31));
            default: rsel = 5'(1 << $urandom_range(0, 4));
         endcase
         seg = $urandom_range(1, 70);
         for (int c = 0; c < seg; c++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0), rsel);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
